// File: rtl/mem_read_buffer_pkg.sv
// mem_read_buffer_pkg
//   Shared definitions for the memory-read capture stage: backplane data
//   width, the word presented after a non-existent-memory timeout, and the
//   read-sequencer state encoding.
package mem_read_buffer_pkg;

  localparam int BUS_W = 36;

  // Word handed to the DBM MEM select when a read times out (NXM).
  localparam logic [0:BUS_W-1] NXM_WORD = 36'o0;

  typedef enum logic [1:0] {
    sIDLE = 2'd0,
    sREQ  = 2'd1,
    sWAIT = 2'd2,
    sDONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_read_buffer_if.sv
// mem_read_buffer_if
//   Bundles the microsequencer handshake, backplane bus and APR flag signals
//   of the memory-read capture stage.
//   slave  : the read buffer itself (takes memREQ/bus inputs, drives results)
//   master : the surrounding environment (CPU sequencer, arbiter, memory)
//   Signals:
//     memREQ    read start pulse            busREQO  bus request to arbiter
//     busGRANT  arbiter grant               busACKI  slave ack, data valid
//     busDATAI  [0:35] bus read data        cpuDATAI [0:35] latched word
//     memWAIT   sequencer stall             nxmFLAG  sticky NXM flag
//     nxmCLR    clears nxmFLAG              protERR  memREQ-while-busy pulse
interface mem_read_buffer_if;
  import mem_read_buffer_pkg::*;

  logic             memREQ;
  logic             busREQO;
  logic             busGRANT;
  logic             busACKI;
  logic [0:BUS_W-1] busDATAI;
  logic [0:BUS_W-1] cpuDATAI;
  logic             memWAIT;
  logic             nxmFLAG;
  logic             nxmCLR;
  logic             protERR;

  modport slave (
    input  memREQ, busGRANT, busACKI, busDATAI, nxmCLR,
    output busREQO, cpuDATAI, memWAIT, nxmFLAG, protERR
  );

  modport master (
    output memREQ, busGRANT, busACKI, busDATAI, nxmCLR,
    input  busREQO, cpuDATAI, memWAIT, nxmFLAG, protERR
  );

endinterface

// File: rtl/mem_read_buffer.sv
// mem_read_buffer
//   Memory-read capture stage feeding the DBM MEM input (cpuDATAI).
//   A memREQ pulse starts a backplane read: request the bus, wait for grant,
//   then wait for ACK or a timeout. The returned word (or NXM_DATA on
//   timeout) is latched and held until the next read completes. memWAIT
//   stalls the microsequencer while the read is outstanding.
//   Ports:
//     clk   clock
//     rst   synchronous reset, active low
//     bus   mem_read_buffer_if.slave (handshake, bus and flag signals)
//   All outputs come straight from flops or from a decode of the state
//   register, so there is no combinational path from bus inputs to outputs.
module mem_read_buffer
  import mem_read_buffer_pkg::*;
#(
  parameter int               TO_WIDTH = 7,
  parameter int               TO_LIMIT = 100,   // must be < 2**TO_WIDTH
  parameter logic [0:BUS_W-1] NXM_DATA = NXM_WORD
) (
  input  logic clk,
  input  logic rst,
  mem_read_buffer_if.slave bus
);

  // Timeout fires on the TO_LIMIT-th WAIT cycle without ACK, i.e. when the
  // count of already-elapsed WAIT cycles equals TO_LIMIT-1.
  localparam logic [TO_WIDTH-1:0] LIM_M1 = TO_WIDTH'(TO_LIMIT - 1);

  state_t               state, state_n;
  logic [TO_WIDTH-1:0]  cnt, cnt_n;
  logic [0:BUS_W-1]     data, data_n;
  logic                 nxm, nxm_n;
  logic                 perr, perr_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= sIDLE;
      cnt   <= '0;
      data  <= '0;
      nxm   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      data  <= data_n;
      nxm   <= nxm_n;
      perr  <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data;
    nxm_n   = nxm;
    perr_n  = 1'b0;

    // Clear first so a timeout on the same edge overrides it.
    if (bus.nxmCLR) nxm_n = 1'b0;

    case (state)
      // DONE accepts a new request exactly like IDLE (back-to-back reads).
      sIDLE, sDONE: begin
        if (bus.memREQ)         state_n = sREQ;
        else if (state == sDONE) state_n = sIDLE;
      end

      sREQ: begin
        if (bus.memREQ) perr_n = 1'b1;
        if (bus.busGRANT) begin
          state_n = sWAIT;
          cnt_n   = '0;
        end
      end

      sWAIT: begin
        if (bus.memREQ) perr_n = 1'b1;
        if (bus.busACKI) begin
          // ACK wins over a coincident timeout.
          state_n = sDONE;
          data_n  = bus.busDATAI;
        end else begin
          if (cnt != '1) cnt_n = cnt + 1'b1;   // saturate, never wrap
          if (cnt == LIM_M1) begin
            state_n = sDONE;
            data_n  = NXM_DATA;
            nxm_n   = 1'b1;
          end
        end
      end

      default: state_n = sIDLE;
    endcase
  end

  assign bus.busREQO  = (state == sREQ);
  assign bus.memWAIT  = (state == sREQ) || (state == sWAIT);
  assign bus.cpuDATAI = data;
  assign bus.nxmFLAG  = nxm;
  assign bus.protERR  = perr;

endmodule

// File: tb/tb_mem_read_buffer.sv
// tb_mem_read_buffer
//   Self-checking bench for mem_read_buffer: a table of per-cycle vectors
//   with hand-computed expected outputs, hand-written timeout sequences, and
//   a randomized run compared against a transaction-level reference model.
module tb_mem_read_buffer;
  import mem_read_buffer_pkg::*;

  localparam int TO_LIMIT = 100;
  localparam logic [35:0] W1 = 36'o123456701234;
  localparam logic [35:0] W2 = 36'o765432107654;
  localparam logic [35:0] W3 = 36'o111122223333;
  localparam logic [35:0] W4 = 36'o444455556666;
  localparam logic [35:0] W5 = 36'o777700001111;
  localparam logic [35:0] W6 = 36'o525252525252;
  localparam logic [35:0] JK = 36'o707070707070;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errs   = 0;

  mem_read_buffer_if bus ();

  mem_read_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  // busy: a read is outstanding; granted: bus owned, now waiting for data;
  // m_n: WAIT cycles elapsed without ACK.
  bit          m_busy, m_granted, m_nxm, m_perr;
  int          m_n;
  logic [35:0] m_data;

  task automatic model_edge();
    if (!rst) begin
      m_busy = 0; m_granted = 0; m_nxm = 0; m_perr = 0; m_n = 0; m_data = '0;
    end else begin
      m_perr = m_busy && bus.memREQ;
      if (bus.nxmCLR) m_nxm = 0;
      if (!m_busy) begin
        if (bus.memREQ) begin m_busy = 1; m_granted = 0; end
      end else if (!m_granted) begin
        if (bus.busGRANT) begin m_granted = 1; m_n = 0; end
      end else if (bus.busACKI) begin
        m_data = bus.busDATAI; m_busy = 0;
      end else begin
        m_n++;
        if (m_n == TO_LIMIT) begin
          m_data = NXM_WORD; m_nxm = 1; m_busy = 0;
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %o expected %o", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic e_wait,
                         input logic e_nxm, input logic e_perr, input logic [35:0] e_data);
    chk({tag, ".busREQO"},  36'(bus.busREQO), 36'(e_req));
    chk({tag, ".memWAIT"},  36'(bus.memWAIT), 36'(e_wait));
    chk({tag, ".nxmFLAG"},  36'(bus.nxmFLAG), 36'(e_nxm));
    chk({tag, ".protERR"},  36'(bus.protERR), 36'(e_perr));
    chk({tag, ".cpuDATAI"}, 36'(bus.cpuDATAI), e_data);
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle.
  task automatic cyc(input logic r, input logic q, input logic g, input logic a,
                     input logic c, input logic [35:0] d);
    rst = r; bus.memREQ = q; bus.busGRANT = g; bus.busACKI = a;
    bus.nxmCLR = c; bus.busDATAI = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, req, gnt, ack, clr;
    logic [35:0] d;
    logic        e_req, e_wait, e_nxm, e_perr;
    logic [35:0] e_data;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic q, logic g, logic a, logic c, logic [35:0] d,
                              logic er, logic ew, logic en, logic ep, logic [35:0] ed);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.ack = a; v.clr = c; v.d = d;
    v.e_req = er; v.e_wait = ew; v.e_nxm = en; v.e_perr = ep; v.e_data = ed;
    return v;
  endfunction

  initial begin
    // Each row: inputs held during a cycle, outputs expected after its edge.
    //               rst q g a c data   req wait nxm perr data
    // reset
    tv.push_back(mk(0, 0,0,0,0, '0,    0,0,0,0, '0));
    tv.push_back(mk(0, 1,1,1,0, JK,    0,0,0,0, '0));
    // normal read: req c0, grant c1, ACK c4 -> data at c5, wait high c1..c4
    tv.push_back(mk(1, 1,0,0,0, '0,    1,1,0,0, '0));
    tv.push_back(mk(1, 0,1,0,0, '0,    0,1,0,0, '0));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,1,0,0, '0));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,1,0,0, '0));
    tv.push_back(mk(1, 0,0,1,0, W1,    0,0,0,0, W1));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,0,0,0, W1));
    // memREQ in REQ and in WAIT: protERR pulses, one read only
    tv.push_back(mk(1, 1,0,0,0, '0,    1,1,0,0, W1));
    tv.push_back(mk(1, 1,0,0,0, '0,    1,1,0,1, W1));
    tv.push_back(mk(1, 0,1,0,0, '0,    0,1,0,0, W1));
    tv.push_back(mk(1, 1,0,0,0, '0,    0,1,0,1, W1));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,1,0,0, W1));
    tv.push_back(mk(1, 0,0,1,0, W2,    0,0,0,0, W2));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,0,0,0, W2));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,0,0,0, W2));
    // back-to-back, stray ACK in DONE/REQ and stray grant in WAIT ignored
    tv.push_back(mk(1, 1,0,0,0, '0,    1,1,0,0, W2));
    tv.push_back(mk(1, 0,1,0,0, '0,    0,1,0,0, W2));
    tv.push_back(mk(1, 0,0,1,0, W3,    0,0,0,0, W3));
    tv.push_back(mk(1, 1,0,1,0, JK,    1,1,0,0, W3));
    tv.push_back(mk(1, 0,1,1,0, JK,    0,1,0,0, W3));
    tv.push_back(mk(1, 0,1,0,0, JK,    0,1,0,0, W3));
    tv.push_back(mk(1, 0,0,1,0, W4,    0,0,0,0, W4));
    tv.push_back(mk(1, 0,0,0,0, '0,    0,0,0,0, W4));
    // reset in WAIT, late ACK and idle grant ignored
    tv.push_back(mk(1, 1,0,0,0, '0,    1,1,0,0, W4));
    tv.push_back(mk(1, 0,1,0,0, '0,    0,1,0,0, W4));
    tv.push_back(mk(0, 0,0,0,0, '0,    0,0,0,0, '0));
    tv.push_back(mk(1, 0,0,1,0, W5,    0,0,0,0, '0));
    tv.push_back(mk(1, 0,1,0,0, '0,    0,0,0,0, '0));

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rst, tv[i].req, tv[i].gnt, tv[i].ack, tv[i].clr, tv[i].d);
      chk_all($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_wait, tv[i].e_nxm,
              tv[i].e_perr, tv[i].e_data);
    end

    // ---------------- NXM timeout ----------------
    cyc(1, 1,0,0,0, '0); cyc(1, 0,1,0,0, '0); cyc(1, 0,0,1,0, W6);  // data = W6
    cyc(1, 1,0,0,0, '0); cyc(1, 0,1,0,0, '0);                      // now in WAIT
    for (int j = 1; j <= TO_LIMIT; j++) begin
      cyc(1, 0,0,0,0, '0);
      if (j == TO_LIMIT - 1) chk_all("nxm_pre", 0, 1, 0, 0, W6);
      if (j == TO_LIMIT)     chk_all("nxm_hit", 0, 0, 1, 0, NXM_WORD);
    end
    cyc(1, 0,0,0,0, '0);  chk_all("nxm_hold", 0, 0, 1, 0, NXM_WORD);
    cyc(1, 0,0,0,1, '0);  chk_all("nxm_clr",  0, 0, 0, 0, NXM_WORD);

    // set wins over a simultaneous clear
    cyc(1, 1,0,0,0, '0); cyc(1, 0,1,0,0, '0);
    for (int j = 1; j <= TO_LIMIT; j++) cyc(1, 0,0,0,1, '0);
    chk_all("nxm_setwins", 0, 0, 1, 0, NXM_WORD);
    cyc(1, 0,0,0,1, '0);  chk_all("nxm_clr2", 0, 0, 0, 0, NXM_WORD);

    // ACK on the timeout cycle: data latched, no NXM
    cyc(1, 1,0,0,0, '0); cyc(1, 0,1,0,0, '0);
    for (int j = 1; j < TO_LIMIT; j++) cyc(1, 0,0,0,0, '0);
    cyc(1, 0,0,1,0, W5);
    chk_all("ack_on_to", 0, 0, 0, 0, W5);

    // ---------------- randomized run vs reference model ----------------
    cyc(0, 0,0,0,0, '0);
    for (int seg = 0; seg < 8; seg++) begin
      int ack_pct;
      case (seg % 4)
        0: ack_pct = 0;
        1: ack_pct = 2;
        2: ack_pct = 20;
        default: ack_pct = 60;
      endcase
      for (int k = 0; k < 500; k++) begin
        logic [35:0] d;
        d = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
        cyc(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < ack_pct),
            ($urandom_range(0, 99) < 5),
            d);
        chk_all($sformatf("rnd%0d_%0d", seg, k), m_busy && !m_granted, m_busy,
                m_nxm, m_perr, m_data);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
